// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the datapath width, the funct3 size/sign codes and the FSM state encoding.
package mem_access_unit_pkg;

  localparam int DEF_XLEN = 32;

  // funct3 size/sign codes shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_unit_align.sv
// load_store_align: purely combinational lane logic for the memory stage.
// Ports:
//   addr_lo_i    low two address bits (byte offset within the word)
//   type_i       funct3 size/sign code
//   is_load_i    load access (a store takes precedence upstream)
//   is_store_i   store access
//   wdata_raw_i  store source data
//   rdata_i      raw read word from data memory
//   wdata_o      lane-replicated store data
//   wstrb_o      byte strobes (0 unless a store)
//   ldata_o      sign/zero-extended load data
//   fault_o      misaligned access or unsupported code for the access type
module load_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  type_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_raw_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] ldata_o,
  output logic        fault_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wdata_o = wdata_raw_i;
    wstrb_o = 4'b0000;
    ldata_o = '0;
    fault_o = 1'b0;
    if (is_store_i) begin
      case (type_i)
        F3_B: begin
          wdata_o = {4{wdata_raw_i[7:0]}};
          wstrb_o = 4'b0001 << addr_lo_i;
        end
        F3_H: begin
          wdata_o = {2{wdata_raw_i[15:0]}};
          wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
          fault_o = addr_lo_i[0];
        end
        F3_W: begin
          wstrb_o = 4'b1111;
          fault_o = |addr_lo_i;
        end
        default: fault_o = 1'b1;
      endcase
    end else if (is_load_i) begin
      case (type_i)
        F3_B:  ldata_o = {{24{byte_v[7]}}, byte_v};
        F3_BU: ldata_o = {24'b0, byte_v};
        F3_H: begin
          ldata_o = {{16{half_v[15]}}, half_v};
          fault_o = addr_lo_i[0];
        end
        F3_HU: begin
          ldata_o = {16'b0, half_v};
          fault_o = addr_lo_i[0];
        end
        F3_W: begin
          ldata_o = rdata_i;
          fault_o = |addr_lo_i;
        end
        default: fault_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage controller. Issues one request/ready transaction
// per load/store, stalls upstream while it is pending, and registers MEM/WB.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   mem_*                      EX/MEM controls, address and store source
//   dmem_req/we/addr/wdata/wstrb  registered data-memory request, held during REQ
//   dmem_rdata, dmem_ready     memory response (sampled only in REQ)
//   stall                      combinational upstream hold
//   mem_wb_*                   MEM/WB register outputs consumed by writeback
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata_raw,
  input  logic            mem_MemtoReg,
  input  logic            mem_MemWrite,
  input  logic            mem_RegWrite,
  input  logic [2:0]      mem_Type_Select,
  input  logic [4:0]      mem_WriteReg,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            stall,
  output logic [XLEN-1:0] mem_wb_readdata,
  output logic [XLEN-1:0] mem_wb_alu_result,
  output logic            mem_wb_MemtoReg,
  output logic            mem_wb_RegWrite,
  output logic [4:0]      mem_wb_WriteReg,
  output logic            mem_wb_misaligned
);

  state_t          state_q;
  logic            req_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q, ldata_q;
  logic [3:0]      wstrb_q;
  logic [XLEN-1:0] rd_q, alu_q;
  logic            m2r_q, rw_q, mis_q;
  logic [4:0]      wr_q;

  logic            is_store, is_load, is_acc, fault, stall_c;
  logic [XLEN-1:0] wdata_c, ldata_c;
  logic [3:0]      wstrb_c;

  // A cycle with both controls set is a store.
  assign is_store = mem_MemWrite;
  assign is_load  = mem_MemtoReg & ~mem_MemWrite;
  assign is_acc   = is_store | is_load;

  load_store_align u_align (
    .addr_lo_i   (mem_addr[1:0]),
    .type_i      (mem_Type_Select),
    .is_load_i   (is_load),
    .is_store_i  (is_store),
    .wdata_raw_i (mem_wdata_raw),
    .rdata_i     (dmem_rdata),
    .wdata_o     (wdata_c),
    .wstrb_o     (wstrb_c),
    .ldata_o     (ldata_c),
    .fault_o     (fault)
  );

  // Stall never looks at dmem_ready; DONE releases so EX/MEM advances once.
  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      S_IDLE:  stall_c = is_acc & ~fault;
      S_REQ:   stall_c = 1'b1;
      default: stall_c = 1'b0;
    endcase
  end
  assign stall = stall_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0;
      ldata_q <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      mis_q   <= 1'b0;
      wr_q    <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_acc && !fault) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {mem_addr[XLEN-1:2], 2'b00};
            wdata_q <= is_store ? wdata_c : '0;
            wstrb_q <= is_store ? wstrb_c : 4'b0;
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            state_q <= S_DONE;
            ldata_q <= ldata_c;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= 4'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // MEM/WB: bubble while stalled, otherwise capture the instruction.
      if (stall_c) begin
        m2r_q <= 1'b0;
        rw_q  <= 1'b0;
        mis_q <= 1'b0;
      end else begin
        alu_q <= mem_addr;
        wr_q  <= mem_WriteReg;
        m2r_q <= is_load & ~fault;
        rw_q  <= mem_RegWrite & ~fault;
        mis_q <= fault;
        rd_q  <= (is_load && !fault) ? ldata_q : '0;
      end
    end
  end

  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign dmem_wstrb        = wstrb_q;
  assign mem_wb_readdata   = rd_q;
  assign mem_wb_alu_result = alu_q;
  assign mem_wb_MemtoReg   = m2r_q;
  assign mem_wb_RegWrite   = rw_q;
  assign mem_wb_WriteReg   = wr_q;
  assign mem_wb_misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clock, reset;
  logic [31:0] mem_addr, mem_wdata_raw;
  logic        mem_MemtoReg, mem_MemWrite, mem_RegWrite;
  logic [2:0]  mem_Type_Select;
  logic [4:0]  mem_WriteReg;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        stall;
  logic [31:0] mem_wb_readdata, mem_wb_alu_result;
  logic        mem_wb_MemtoReg, mem_wb_RegWrite, mem_wb_misaligned;
  logic [4:0]  mem_wb_WriteReg;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata_raw(mem_wdata_raw),
    .mem_MemtoReg(mem_MemtoReg), .mem_MemWrite(mem_MemWrite),
    .mem_RegWrite(mem_RegWrite), .mem_Type_Select(mem_Type_Select),
    .mem_WriteReg(mem_WriteReg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall(stall),
    .mem_wb_readdata(mem_wb_readdata), .mem_wb_alu_result(mem_wb_alu_result),
    .mem_wb_MemtoReg(mem_wb_MemtoReg), .mem_wb_RegWrite(mem_wb_RegWrite),
    .mem_wb_WriteReg(mem_wb_WriteReg), .mem_wb_misaligned(mem_wb_misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic ld, input logic st, input logic rw,
                       input logic [2:0] ty, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] wr);
    mem_MemtoReg    = ld;
    mem_MemWrite    = st;
    mem_RegWrite    = rw;
    mem_Type_Select = ty;
    mem_addr        = a;
    mem_wdata_raw   = wd;
    mem_WriteReg    = wr;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    instr(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick; tick;
    chk("rst_req", dmem_req, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_rw", mem_wb_RegWrite, 0);
    chk("rst_alu", mem_wb_alu_result, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b0;

    // SW 0x104, ready already high on first REQ cycle
    dmem_ready = 1'b1;
    instr(0, 1, 0, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0);
    chk("sw_stall0", stall, 1);
    tick;
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_addr", dmem_addr, 32'h104);
    chk("sw_wstrb", dmem_wstrb, 4'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall1", stall, 1);
    tick;
    chk("sw_done_stall", stall, 0);
    chk("sw_done_req", dmem_req, 0);
    tick;
    chk("sw_wb_rw", mem_wb_RegWrite, 0);
    chk("sw_wb_alu", mem_wb_alu_result, 32'h104);

    // LB 0x103 -> byte 0x80 sign-extended
    dmem_rdata = 32'h80FF_FF00;
    instr(1, 0, 1, 3'b000, 32'h103, 32'h0, 5'd5);
    chk("lb_stall0", stall, 1);
    tick;
    chk("lb_we", dmem_we, 0);
    chk("lb_wstrb", dmem_wstrb, 0);
    chk("lb_addr", dmem_addr, 32'h100);
    tick; tick;
    chk("lb_data", mem_wb_readdata, 32'hFFFFFF80);
    chk("lb_m2r", mem_wb_MemtoReg, 1);
    chk("lb_rw", mem_wb_RegWrite, 1);
    chk("lb_wr", mem_wb_WriteReg, 5);

    // LBU same address -> zero-extended
    instr(1, 0, 1, 3'b100, 32'h103, 32'h0, 5'd6);
    tick; tick; tick;
    chk("lbu_data", mem_wb_readdata, 32'h00000080);

    // SH 0x202 -> upper half lanes
    instr(0, 1, 0, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
    tick;
    chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh_wstrb", dmem_wstrb, 4'b1100);
    chk("sh_addr", dmem_addr, 32'h200);
    tick; tick;
    chk("sh_wb_rd", mem_wb_readdata, 0);

    // LW misaligned: no request, no stall, one-cycle fault
    instr(1, 0, 1, 3'b010, 32'h102, 32'h0, 5'd9);
    chk("mis_stall", stall, 0);
    tick;
    chk("mis_req", dmem_req, 0);
    chk("mis_flag", mem_wb_misaligned, 1);
    chk("mis_rw", mem_wb_RegWrite, 0);
    chk("mis_alu", mem_wb_alu_result, 32'h102);

    // Unsupported store code faults as well
    instr(0, 1, 0, 3'b100, 32'h0, 32'h0, 5'd0);
    chk("bad_stall", stall, 0);
    tick;
    chk("bad_flag", mem_wb_misaligned, 1);

    // LW with ready delayed 4 cycles: req high for 5 cycles
    dmem_ready = 1'b0;
    dmem_rdata = 32'hCAFEF00D;
    instr(1, 0, 1, 3'b010, 32'h108, 32'h0, 5'd12);
    chk("lwd_stall0", stall, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("lwd_req", dmem_req, 1);
      chk("lwd_addr", dmem_addr, 32'h108);
      chk("lwd_stall", stall, 1);
      chk("lwd_bubble", mem_wb_RegWrite, 0);
      tick;
    end
    dmem_ready = 1'b1;
    #1;
    chk("lwd_req5", dmem_req, 1);
    tick;
    dmem_ready = 1'b0;
    chk("lwd_done_req", dmem_req, 0);
    chk("lwd_done_stall", stall, 0);
    tick;
    chk("lwd_data", mem_wb_readdata, 32'hCAFEF00D);
    chk("lwd_rw", mem_wb_RegWrite, 1);
    chk("lwd_wr", mem_wb_WriteReg, 12);
    instr(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick;
    chk("lwd_noreissue", dmem_req, 0);
    chk("lwd_single_wb", mem_wb_RegWrite, 0);

    // Reset during REQ abandons the transaction
    instr(0, 1, 0, 3'b010, 32'h300, 32'h11112222, 5'd0);
    tick;
    chk("rreq_req", dmem_req, 1);
    reset = 1'b1;
    tick;
    chk("rreq_req0", dmem_req, 0);
    chk("rreq_addr0", dmem_addr, 0);
    chk("rreq_wstrb0", dmem_wstrb, 0);
    chk("rreq_alu0", mem_wb_alu_result, 0);
    reset = 1'b0;
    instr(0, 0, 1, 3'b000, 32'h55, 32'h0, 5'd7);
    chk("add_stall", stall, 0);
    tick;
    chk("add_rw", mem_wb_RegWrite, 1);
    chk("add_wr", mem_wb_WriteReg, 7);
    chk("add_alu", mem_wb_alu_result, 32'h55);
    chk("add_rd", mem_wb_readdata, 0);
    chk("add_req", dmem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller of the 5-stage RISC-V pipeline, sitting between the EX/MEM pipeline register and writeback. It turns the EX/MEM load/store controls into a single-outstanding request/ready transaction on the data-memory port, aligns store data and byte strobes, and sign- or zero-extends load data. It stalls the upstream pipeline while a transaction is pending and registers the MEM/WB fields consumed by writeback.

## Interface
Parameters:
- XLEN, default 32 (from `RISCV.h`): datapath width; only 32 is supported.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_addr  in  XLEN  effective address (EX/MEM ALU result).
- mem_wdata_raw  in  XLEN  store source (EX/MEM read data 2).
- mem_MemtoReg  in  1  load instruction.
- mem_MemWrite  in  1  store instruction.
- mem_RegWrite  in  1  writeback enable.
- mem_Type_Select  in  3  funct3 size/sign code.
- mem_WriteReg  in  5  destination register.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word-aligned address, with bits [1:0] = 0.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  4  byte strobes; 0 for reads.
- dmem_rdata  in  XLEN  read data, valid when dmem_ready is high.
- dmem_ready  in  1  transaction complete.
- stall  out  1  combinational; deasserts the EX/MEM enable and all upstream enables.
- mem_wb_readdata  out  XLEN  extended load data.
- mem_wb_alu_result  out  XLEN  pass-through address/result.
- mem_wb_MemtoReg  out  1  load result select.
- mem_wb_RegWrite  out  1  writeback enable.
- mem_wb_WriteReg  out  5  destination register.
- mem_wb_misaligned  out  1  access fault flag.

## Operation
- A cycle is an access when `MemtoReg | MemWrite` is high. If both are set, the cycle is treated as a store.
- Type_Select codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Fault conditions:
  - Misaligned halfword: addr[0] = 1.
  - Misaligned word: addr[1:0] ≠ 0.
  - Any other Type_Select code for the access type.
- On a fault:
  - No bus transaction and no stall.
  - mem_wb_misaligned = 1 and mem_wb_RegWrite = 0.
- FSM states:
  - IDLE: a valid access goes to REQ with stall = 1. A non-access or faulting cycle stays in IDLE with stall = 0.
  - REQ: dmem_req = 1, with all dmem_* outputs registered and held stable; stall = 1. When dmem_ready is sampled high, capture dmem_rdata and go to DONE.
  - DONE: stall = 0. At the closing edge MEM/WB loads the result and the state returns to IDLE, so the instruction issues only once.
- Store lanes:
  - SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 0011 << (2·addr[1]).
  - SW: wstrb = 1111.
- Load extract:
  - Byte lane addr[1:0]; halfword lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- MEM/WB update rules:
  - Updated every cycle.
  - While stall = 1, a bubble is loaded: RegWrite = 0, MemtoReg = 0, misaligned = 0; the other fields hold.
  - For non-load instructions, mem_wb_readdata = 0.
- dmem_ready is ignored outside REQ.

## Timing
- Reset value: every output is 0 and the state is IDLE. A reset during REQ drops dmem_req on the next cycle and abandons the transaction.
- Non-memory or faulting instruction: the result appears on MEM/WB one cycle after it is presented.
- Access latency:
  - Cycles from presentation to stall release = 2 + (cycles dmem_req is high before dmem_ready).
  - Minimum: 3 cycles with stall high for 2.
- dmem_req stays high until the ready edge, and there is at most one outstanding request.
- stall depends combinationally on the inputs and state, but never on dmem_ready.

## Structure
- `RISCV.h` holds XLEN, the funct3 load/store codes, and the state encodings.
- One combinational sub-module, `load_store_align`, handles strobe/wdata generation, load extraction and the fault check. The FSM and MEM/WB registers stay in `mem_access_unit`.

## Test plan
- SW at addr 0x104 with data 0xDEADBEEF, ready on the first REQ cycle:
  - dmem_addr = 0x104, wstrb = 1111, stall high for 2 cycles.
  - mem_wb_RegWrite = 0.
- LB at addr 0x103 with rdata = 0x80FF_FF00 → mem_wb_readdata = 0xFFFFFF80. The same with LBU → 0x00000080.
- SH at addr 0x202 with data 0x1234ABCD → wdata = 0xABCDABCD, wstrb = 1100.
- LW at addr 0x102 → no dmem_req, no stall, mem_wb_misaligned = 1, mem_wb_RegWrite = 0.
- LW with ready delayed 4 cycles → dmem_req stays high and stable for 5 cycles, and bubbles appear on MEM/WB meanwhile. Afterwards: single writeback, no reissue.
- Reset asserted in REQ:
  - dmem_req = 0 and all outputs = 0 next cycle.
  - A following ADD passes through normally.
